// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS32 control path: opcodes, state
// encoding, control strobe bundle and opcode classification. Optional macro: MC_CTRL_HALT_INSTR_EN.
package mc_ctrl_pkg;

  localparam int unsigned OPC_BITS = 6;

  localparam logic [OPC_BITS-1:0] OP_ADD   = 6'b000000;
  localparam logic [OPC_BITS-1:0] OP_SUB   = 6'b000001;
  localparam logic [OPC_BITS-1:0] OP_AND   = 6'b000010;
  localparam logic [OPC_BITS-1:0] OP_OR    = 6'b000011;
  localparam logic [OPC_BITS-1:0] OP_SLT   = 6'b000100;
  localparam logic [OPC_BITS-1:0] OP_MUL   = 6'b000101;
  localparam logic [OPC_BITS-1:0] OP_LW    = 6'b001000;
  localparam logic [OPC_BITS-1:0] OP_SW    = 6'b001001;
  localparam logic [OPC_BITS-1:0] OP_ADDI  = 6'b001010;
  localparam logic [OPC_BITS-1:0] OP_SUBI  = 6'b001011;
  localparam logic [OPC_BITS-1:0] OP_SLTI  = 6'b001100;
  localparam logic [OPC_BITS-1:0] OP_BNEQZ = 6'b001101;
  localparam logic [OPC_BITS-1:0] OP_BEQZ  = 6'b001110;
  localparam logic [OPC_BITS-1:0] OP_HLT   = 6'b111111;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_e;

  typedef enum logic [2:0] {
    CLS_RR  = 3'd0,
    CLS_RI  = 3'd1,
    CLS_LD  = 3'd2,
    CLS_ST  = 3'd3,
    CLS_BR  = 3'd4,
    CLS_ILL = 3'd5,
    CLS_HLT = 3'd6
  } op_cls_e;

  // Datapath strobes and selects produced each cycle by the sequencer
  typedef struct packed {
    logic imem_req;
    logic dmem_req;
    logic mem_wr;
    logic reg_wr;
    logic pc_ld;
    logic sel1;
    logic sel2;
    logic sel3;
    logic sel4;
    logic illegal_op;
  } ctrl_t;

  function automatic op_cls_e op_class(input logic [OPC_BITS-1:0] op);
    op_cls_e cls;
    cls = CLS_ILL;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: cls = CLS_RR;
      OP_ADDI, OP_SUBI, OP_SLTI:                      cls = CLS_RI;
      OP_LW:                                          cls = CLS_LD;
      OP_SW:                                          cls = CLS_ST;
      OP_BNEQZ, OP_BEQZ:                              cls = CLS_BR;
`ifdef MC_CTRL_HALT_INSTR_EN
      OP_HLT:                                         cls = CLS_HLT;
`endif
      default:                                        cls = CLS_ILL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/mc_ctrl_wdog.sv
// Handshake watchdog: counts stalled cycles of one memory wait and flags
// when the configured limit is reached. TMO_CYC=0 disables expiry.
module mc_ctrl_wdog #(
  parameter int unsigned TMO_CYC = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic cnt_i,
  output logic expire_c
);

  localparam int unsigned CNT_W = (TMO_CYC > 2) ? $clog2(TMO_CYC) : 1;
  localparam int unsigned LIMIT = (TMO_CYC > 0) ? TMO_CYC - 1 : 0;
  localparam logic        EN    = (TMO_CYC != 0);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturates at LIMIT; the current stalled cycle is the one that expires
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (cnt_i && (cnt_q != CNT_W'(LIMIT))) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_c = EN && (cnt_q == CNT_W'(LIMIT));

endmodule

// File: rtl/mc_ctrl_path.sv
// Multi-cycle MIPS32 control path: latches the instruction and sequences
// fetch/decode/exec/mem/wb with req/ack memories. Optional macro: MC_CTRL_HALT_INSTR_EN.
module mc_ctrl_path
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned IR_W    = 32,
  parameter int unsigned OPC_W   = 6,
  parameter int unsigned RA_W    = 5,
  parameter int unsigned TMO_CYC = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IR_W-1:0]   instr_in,
  input  logic              imem_ack,
  input  logic              dmem_ack,
  input  logic              EQZ,
  output logic              imem_req,
  output logic              dmem_req,
  output logic              mem_wr,
  output logic              reg_wr,
  output logic              pc_ld,
  output logic              sel1,
  output logic              sel2,
  output logic              sel3,
  output logic              sel4,
  output logic [OPC_W-1:0]  opcode,
  output logic [RA_W-1:0]   rs1,
  output logic [RA_W-1:0]   rs2,
  output logic [RA_W-1:0]   rd,
  output logic              illegal_op,
  output logic              bus_err,
  output logic [2:0]        state
);

  localparam int unsigned RS1_HI = IR_W - OPC_W - 1;
  localparam int unsigned RS2_HI = RS1_HI - RA_W;
  localparam int unsigned RD_HI  = RS2_HI - RA_W;
  localparam int unsigned IMM_HI = RD_HI - RA_W;

  state_e            state_q, state_d;
  logic [IR_W-1:0]   ir_q, ir_d;
  logic              bus_err_q, bus_err_d;
  ctrl_t             ctrl_c;
  logic [RA_W-1:0]   rd_c;
  logic              wd_clr, wd_cnt, wd_exp;

  logic [OPC_W-1:0]    opc_f;
  logic [OPC_BITS-1:0] opc6;
  logic [RA_W-1:0]     rs1_f, rs2_f, rd_f;
  op_cls_e             cls;
  logic                is_beqz;
  logic                unused_imm;

  assign opc_f      = ir_q[IR_W-1 -: OPC_W];
  assign rs1_f      = ir_q[RS1_HI -: RA_W];
  assign rs2_f      = ir_q[RS2_HI -: RA_W];
  assign rd_f       = ir_q[RD_HI -: RA_W];
  assign unused_imm = ^ir_q[IMM_HI:0];
  assign opc6       = OPC_BITS'(opc_f);
  assign cls        = op_class(opc6);
  assign is_beqz    = (opc6 == OP_BEQZ);

  // Sequencer: next state, IR capture, timeout handling and strobes
  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    bus_err_d = bus_err_q;
    ctrl_c    = '0;
    rd_c      = '0;
    wd_cnt    = 1'b0;
    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        ctrl_c.imem_req = 1'b1;
        if (imem_ack) begin
          ir_d    = instr_in;
          state_d = S_DECODE;
        end else begin
          wd_cnt = 1'b1;
          if (wd_exp) begin
            bus_err_d = 1'b1;
            state_d   = S_HALT;
          end
        end
      end
      S_DECODE: begin
        state_d = S_EXEC;
      end
      S_EXEC: begin
        case (cls)
          CLS_RR: begin
            ctrl_c.sel1 = 1'b1;
            state_d     = S_WB;
          end
          CLS_RI: begin
            ctrl_c.sel1 = 1'b1;
            ctrl_c.sel2 = 1'b1;
            state_d     = S_WB;
          end
          CLS_LD, CLS_ST: begin
            ctrl_c.sel1 = 1'b1;
            ctrl_c.sel2 = 1'b1;
            state_d     = S_MEM;
          end
          CLS_BR: begin
            ctrl_c.sel2  = 1'b1;
            ctrl_c.pc_ld = 1'b1;
            ctrl_c.sel3  = is_beqz ? EQZ : !EQZ;
            state_d      = S_FETCH;
          end
          CLS_HLT: begin
            state_d = S_HALT;
          end
          default: begin
            ctrl_c.illegal_op = 1'b1;
            ctrl_c.pc_ld      = 1'b1;
            state_d           = S_FETCH;
          end
        endcase
      end
      S_MEM: begin
        ctrl_c.dmem_req = 1'b1;
        ctrl_c.mem_wr   = (cls == CLS_ST);
        if (dmem_ack) begin
          if (cls == CLS_ST) begin
            ctrl_c.pc_ld = 1'b1;
            state_d      = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else begin
          wd_cnt = 1'b1;
          if (wd_exp) begin
            bus_err_d = 1'b1;
            state_d   = S_HALT;
          end
        end
      end
      S_WB: begin
        ctrl_c.reg_wr = 1'b1;
        ctrl_c.pc_ld  = 1'b1;
        ctrl_c.sel4   = (cls != CLS_LD);
        rd_c          = (cls == CLS_RR) ? rd_f : rs2_f;
        state_d       = S_FETCH;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      ir_q      <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      bus_err_q <= bus_err_d;
    end
  end

  // Every state change opens a fresh wait window
  assign wd_clr = (state_d != state_q);

  mc_ctrl_wdog #(
    .TMO_CYC (TMO_CYC)
  ) u_wdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (wd_clr),
    .cnt_i    (wd_cnt),
    .expire_c (wd_exp)
  );

  assign imem_req   = ctrl_c.imem_req;
  assign dmem_req   = ctrl_c.dmem_req;
  assign mem_wr     = ctrl_c.mem_wr;
  assign reg_wr     = ctrl_c.reg_wr;
  assign pc_ld      = ctrl_c.pc_ld;
  assign sel1       = ctrl_c.sel1;
  assign sel2       = ctrl_c.sel2;
  assign sel3       = ctrl_c.sel3;
  assign sel4       = ctrl_c.sel4;
  assign illegal_op = ctrl_c.illegal_op;
  assign rd         = rd_c;
  assign opcode     = opc_f;
  assign rs1        = rs1_f;
  assign rs2        = rs2_f;
  assign bus_err    = bus_err_q;
  assign state      = state_q;

endmodule

// File: tb/tb_mc_ctrl_path.sv
// Scoreboard bench for mc_ctrl_path: directed instructions push expected
// end-of-instruction snapshots; a monitor compares them when pc_ld or bus_err fires.
module tb_mc_ctrl_path;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr_in = '0;
  logic        imem_ack = 1'b0;
  logic        dmem_ack = 1'b0;
  logic        EQZ = 1'b0;
  logic        imem_req, dmem_req, mem_wr, reg_wr, pc_ld;
  logic        sel1, sel2, sel3, sel4;
  logic [5:0]  opcode;
  logic [4:0]  rs1, rs2, rd;
  logic        illegal_op, bus_err;
  logic [2:0]  state;

  int checks = 0;
  int failures = 0;
  int cyc;

  typedef struct packed {
    logic [7:0] cyc;
    logic [2:0] st;
    logic       rw;
    logic [4:0] rd;
    logic       dr;
    logic       mw;
    logic [3:0] sel;
    logic       ill;
    logic       be;
  } obs_t;

  typedef struct {
    logic [31:0] instr;
    int          id;
    int          dd;
    logic        eqz;
    logic        mem;
    obs_t        exp;
  } vec_t;

  obs_t exp_q[$];

  mc_ctrl_path #(
    .IR_W(32), .OPC_W(6), .RA_W(5), .TMO_CYC(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .instr_in(instr_in), .imem_ack(imem_ack),
    .dmem_ack(dmem_ack), .EQZ(EQZ), .imem_req(imem_req), .dmem_req(dmem_req),
    .mem_wr(mem_wr), .reg_wr(reg_wr), .pc_ld(pc_ld), .sel1(sel1), .sel2(sel2),
    .sel3(sel3), .sel4(sel4), .opcode(opcode), .rs1(rs1), .rs2(rs2), .rd(rd),
    .illegal_op(illegal_op), .bus_err(bus_err), .state(state)
  );

  always #5 clk = ~clk;

  // Cycle 1 is the IDLE cycle right after reset release
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 1;
    else        cyc <= cyc + 1;
  end

  function automatic obs_t mk_obs(input int c, input logic [2:0] st, input logic rw,
                                  input logic [4:0] rdv, input logic dr, input logic mw,
                                  input logic [3:0] sel, input logic ill, input logic be);
    obs_t o;
    o.cyc = 8'(c); o.st = st; o.rw = rw; o.rd = rdv; o.dr = dr; o.mw = mw;
    o.sel = sel; o.ill = ill; o.be = be;
    return o;
  endfunction

  function automatic vec_t mk_vec(input logic [31:0] ins, input int id, input int dd,
                                  input logic eqz, input logic mem, input obs_t e);
    vec_t v;
    v.instr = ins; v.id = id; v.dd = dd; v.eqz = eqz; v.mem = mem; v.exp = e;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_req(input bit is_dmem, output bit ok);
    int n;
    n  = 0;
    ok = 1'b1;
    while (!(is_dmem ? dmem_req : imem_req)) begin
      if (n == 40) begin
        ok = 1'b0;
        return;
      end
      step();
      n++;
    end
  endtask

  task automatic run_vec(input vec_t v);
    bit ok;
    wait_req(1'b0, ok);
    chk("imem_req_seen", 32'(ok), 32'd1);
    if (!ok) return;
    EQZ = v.eqz;
    exp_q.push_back(v.exp);
    repeat (v.id) step();
    imem_ack = 1'b1;
    instr_in = v.instr;
    step();
    imem_ack = 1'b0;
    if (v.mem) begin
      wait_req(1'b1, ok);
      chk("dmem_req_seen", 32'(ok), 32'd1);
      if (!ok) return;
      repeat (v.dd) step();
      dmem_ack = 1'b1;
      step();
      dmem_ack = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    EQZ      = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
  endtask

  // Monitor: one snapshot per instruction end (pc_ld) or timeout entry
  initial begin : monitor
    logic be_prev;
    obs_t a, e;
    be_prev = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        be_prev = 1'b0;
      end else begin
        if (pc_ld || (bus_err && !be_prev)) begin
          a = mk_obs(cyc, state, reg_wr, rd, dmem_req, mem_wr,
                     {sel1, sel2, sel3, sel4}, illegal_op, bus_err);
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event cyc=%0d actual=%h expected=none", cyc, a);
          end else begin
            e = exp_q.pop_front();
            if (a !== e) begin
              failures++;
              $display("FAIL event cyc=%0d actual=%h expected=%h", cyc, a, e);
            end
          end
        end
        be_prev = bus_err;
      end
    end
  end

  initial begin : guard
    #100000;
    $display("FAIL global_timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin : stim
    vec_t prog[$];
    vec_t add_v;

    add_v = mk_vec(32'h0022_1800, 0, 0, 1'b0, 1'b0, mk_obs(5, 3'd5, 1, 5'd3, 0, 0, 4'b0001, 0, 0));
    prog.push_back(add_v);
    prog.push_back(mk_vec(32'h2024_0010, 1, 3, 1'b0, 1'b1, mk_obs(14, 3'd5, 1, 5'd4, 0, 0, 4'b0000, 0, 0)));
    prog.push_back(mk_vec(32'h2425_0008, 0, 1, 1'b0, 1'b1, mk_obs(19, 3'd4, 0, 5'd0, 1, 1, 4'b0000, 0, 0)));
    prog.push_back(mk_vec(32'h3820_0010, 0, 0, 1'b1, 1'b0, mk_obs(22, 3'd3, 0, 5'd0, 0, 0, 4'b0110, 0, 0)));
    prog.push_back(mk_vec(32'h3420_0010, 0, 0, 1'b1, 1'b0, mk_obs(25, 3'd3, 0, 5'd0, 0, 0, 4'b0100, 0, 0)));
    prog.push_back(mk_vec(32'h3420_0010, 0, 0, 1'b0, 1'b0, mk_obs(28, 3'd3, 0, 5'd0, 0, 0, 4'b0110, 0, 0)));
    prog.push_back(mk_vec(32'h4000_0000, 0, 0, 1'b0, 1'b0, mk_obs(31, 3'd3, 0, 5'd0, 0, 0, 4'b0000, 1, 0)));
    prog.push_back(mk_vec(32'h2847_0005, 3, 0, 1'b0, 1'b0, mk_obs(38, 3'd5, 1, 5'd7, 0, 0, 4'b0001, 0, 0)));
`ifndef MC_CTRL_HALT_INSTR_EN
    prog.push_back(mk_vec(32'hFC00_0000, 0, 0, 1'b0, 1'b0, mk_obs(41, 3'd3, 0, 5'd0, 0, 0, 4'b0000, 1, 0)));
`endif

    // Reset values
    step();
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_strobes", 32'({imem_req, dmem_req, mem_wr, reg_wr, pc_ld, illegal_op}), 32'd0);
    chk("rst_selects", 32'({sel1, sel2, sel3, sel4}), 32'd0);
    chk("rst_ir_fields", 32'({opcode, rs1, rs2, rd}), 32'd0);
    chk("rst_bus_err", 32'(bus_err), 32'd0);

    // Instruction stream
    do_reset();
    foreach (prog[i]) run_vec(prog[i]);
    repeat (6) step();

    // Fetch timeout: four stalled FETCH cycles then HALT
    do_reset();
    exp_q.push_back(mk_obs(6, 3'd6, 0, 5'd0, 0, 0, 4'b0000, 0, 1));
    begin
      int n;
      n = 0;
      while (!bus_err && n < 20) begin
        step();
        n++;
      end
    end
    #1;
    chk("tmo_bus_err", 32'(bus_err), 32'd1);
    chk("tmo_state", 32'(state), 32'd6);
    imem_ack = 1'b1;
    instr_in = 32'h0022_1800;
    repeat (3) step();
    #1;
    chk("halt_ignores_ack_state", 32'(state), 32'd6);
    chk("halt_strobes", 32'({imem_req, dmem_req, reg_wr, pc_ld}), 32'd0);
    chk("halt_bus_err_sticky", 32'(bus_err), 32'd1);
    imem_ack = 1'b0;

    // Reset in the middle of an SW memory wait
    do_reset();
    begin
      bit ok;
      wait_req(1'b0, ok);
      chk("sw_imem_req_seen", 32'(ok), 32'd1);
      imem_ack = 1'b1;
      instr_in = 32'h2425_0008;
      step();
      imem_ack = 1'b0;
      wait_req(1'b1, ok);
      chk("sw_dmem_req_seen", 32'(ok), 32'd1);
    end
    step();
    #1;
    chk("sw_mem_req", 32'({dmem_req, mem_wr}), 32'b11);
    rst_n = 1'b0;
    #1;
    chk("abort_req_drop", 32'({dmem_req, mem_wr}), 32'b00);
    chk("abort_state", 32'(state), 32'd0);
    chk("abort_bus_err", 32'(bus_err), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    #1;
    chk("post_rst_idle", 32'(state), 32'd0);
    step();
    #1;
    chk("post_rst_fetch", 32'(state), 32'd1);
    run_vec(add_v);
    repeat (6) step();

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
